// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell is fed one operand bit
// pair per clock, LSB first. A carry flip-flop closes the loop between the
// cell's carry-out and carry-in. Results are registered and held until the
// next addition completes.

// Single-bit full adder cell.
module fulladder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_PREV = CW'(WIDTH - 2);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] acc_q;
    logic             carry_q;
    logic             prev_carry_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             c_out_q;
    logic             overflow_q;

    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] acc_d;

    fulladder u_fa (
        .a_i (opa_q[0]),
        .b_i (opb_q[0]),
        .c_i (carry_q),
        .s_o (fa_sum),
        .c_o (fa_cout)
    );

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 is the LSB.
    assign acc_d = {fa_sum, acc_q[WIDTH-1:1]};

    // Sequencer: operand capture, per-bit shifting and result registration.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            opa_q        <= '0;
            opb_q        <= '0;
            acc_q        <= '0;
            carry_q      <= 1'b0;
            prev_carry_q <= 1'b0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            sum_q        <= '0;
            c_out_q      <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        opa_q   <= a;
                        opb_q   <= b;
                        carry_q <= c_in;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    opa_q   <= opa_q >> 1;
                    opb_q   <= opb_q >> 1;
                    acc_q   <= acc_d;
                    carry_q <= fa_cout;
                    cnt_q   <= cnt_q + CNT_ONE;
                    // Carry into the MSB, needed for the overflow flag.
                    if (cnt_q == CNT_PREV) begin
                        prev_carry_q <= fa_cout;
                    end else begin
                        prev_carry_q <= prev_carry_q;
                    end
                    if (cnt_q == CNT_LAST) begin
                        sum_q      <= acc_d;
                        c_out_q    <= fa_cout;
                        overflow_q <= fa_cout ^ prev_carry_q;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= S_IDLE;
                    end else begin
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sum      = sum_q;
    assign c_out    = c_out_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed vector table, handshake and
// reset corner cases on an 8-bit instance, randomized operations against an
// arithmetic reference model, and an exhaustive sweep of a 4-bit instance.
`timescale 1ns/1ps

module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, c8, busy8, done8, cout8, ovf8;
    logic [7:0] a8, b8, sum8;
    logic       start4, c4, busy4, done4, cout4, ovf4;
    logic [3:0] a4, b4, sum4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .c_in(c8),
        .busy(busy8), .done(done8), .sum(sum8), .c_out(cout8), .overflow(ovf8)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .c_in(c4),
        .busy(busy4), .done(done4), .sum(sum4), .c_out(cout4), .overflow(ovf4)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic; overflow = signed result out of range.
    task automatic model(input int w, input int ua, input int ub, input int uc,
                         output int es, output int ec, output int eo);
        int full, sa, sb, ss;
        full = ua + ub + uc;
        es   = full % (1 << w);
        ec   = full / (1 << w);
        sa   = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
        sb   = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
        ss   = sa + sb + uc;
        eo   = (ss > (1 << (w - 1)) - 1 || ss < -(1 << (w - 1))) ? 1 : 0;
    endtask

    // One 8-bit operation with latency, busy-length and done-width checks.
    task automatic op8(input logic [7:0] ta, input logic [7:0] tb2, input logic tc,
                       input int es, input int ec, input int eo, input string nm);
        int lat, nbusy;
        @(negedge clk);
        a8 = ta; b8 = tb2; c8 = tc; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
        lat = 0; nbusy = 0;
        while (done8 !== 1'b1 && lat < 20) begin
            if (busy8 === 1'b1) nbusy++;
            @(negedge clk);
            lat++;
        end
        chk({nm, " latency"}, lat, 8);
        chk({nm, " busy cycles"}, nbusy, 8);
        chk({nm, " busy in done"}, int'(busy8), 0);
        chk({nm, " sum"}, int'(sum8), es);
        chk({nm, " c_out"}, int'(cout8), ec);
        chk({nm, " overflow"}, int'(ovf8), eo);
        @(negedge clk);
        chk({nm, " done width"}, int'(done8), 0);
    endtask

    // One 4-bit operation; done must come exactly 4 edges after acceptance.
    task automatic op4(input int ta, input int tb2, input int tc);
        int lat, es, ec, eo;
        model(4, ta, tb2, tc, es, ec, eo);
        @(negedge clk);
        a4 = 4'(ta); b4 = 4'(tb2); c4 = 1'(tc); start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        lat = 0;
        while (done4 !== 1'b1 && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        if (lat != 4 || sum4 !== 4'(es) || cout4 !== 1'(ec) || ovf4 !== 1'(eo)
            || busy4 !== 1'b0) begin
            errors++;
            $display("FAIL w4 a=%0h b=%0h c=%0d: got lat=%0d sum=%0h co=%0b ov=%0b busy=%0b expected lat=4 sum=%0h co=%0d ov=%0d busy=0",
                     ta, tb2, tc, lat, sum4, cout4, ovf4, busy4, es, ec, eo);
        end
        checks++;
    endtask

    initial begin
        int es, ec, eo, cnt, ra, rb, rc;
        logic [7:0] held;

        vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[5] = '{8'h3C, 8'h5A, 1'b1, 8'h97, 1'b0, 1'b1};

        rst = 1'b1; start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;
        start4 = 1'b0; a4 = 4'h0; b4 = 4'h0; c4 = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset busy", int'(busy8), 0);
        chk("reset done", int'(done8), 0);
        chk("reset sum", int'(sum8), 0);
        chk("reset c_out", int'(cout8), 0);
        chk("reset overflow", int'(ovf8), 0);
        chk("reset w4 outputs", int'({busy4, done4, sum4, cout4, ovf4}), 0);
        rst = 1'b0;

        // Directed vector table
        for (int i = 0; i < 6; i++) begin
            op8(vecs[i].a, vecs[i].b, vecs[i].cin, int'(vecs[i].sum),
                int'(vecs[i].cout), int'(vecs[i].ovf), $sformatf("vec%0d", i));
        end

        // Randomized operations against the model
        for (int i = 0; i < 30; i++) begin
            ra = int'($urandom_range(255)); rb = int'($urandom_range(255));
            rc = int'($urandom_range(1));
            model(8, ra, rb, rc, es, ec, eo);
            op8(8'(ra), 8'(rb), 1'(rc), es, ec, eo, $sformatf("rand%0d", i));
        end

        // Handshake: start ignored during RUN, back-to-back start in done cycle
        @(negedge clk);
        held = sum8;
        a8 = 8'h12; b8 = 8'h34; c8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        a8 = 8'hF0; b8 = 8'h0F; c8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        cnt = 4;
        while (done8 !== 1'b1 && cnt < 20) begin
            if (sum8 !== held) chk("hs sum held during run", int'(sum8), int'(held));
            @(negedge clk);
            cnt++;
        end
        chk("hs first latency", cnt, 8);
        chk("hs first sum", int'(sum8), 8'h46);
        a8 = 8'h80; b8 = 8'h7F; c8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        chk("hs second accepted busy", int'(busy8), 1);
        cnt = 1;
        while (done8 !== 1'b1 && cnt < 20) begin
            if (sum8 !== 8'h46) chk("hs first sum held", int'(sum8), 8'h46);
            @(negedge clk);
            cnt++;
        end
        chk("hs done spacing", cnt, 9);
        chk("hs second sum", int'(sum8), 8'h00);
        chk("hs second c_out", int'(cout8), 1);
        chk("hs second overflow", int'(ovf8), 0);

        // Reset in the middle of an operation
        op8(8'h10, 8'h21, 1'b0, 8'h31, 0, 0, "pre-reset");
        @(negedge clk);
        a8 = 8'h55; b8 = 8'hAA; c8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort outputs cleared", int'({busy8, done8, sum8, cout8, ovf8}), 0);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8 === 1'b1 || busy8 === 1'b1) cnt++;
        end
        chk("abort no done or busy afterwards", cnt, 0);
        op8(8'h01, 8'h02, 1'b0, 8'h03, 0, 0, "post-reset");

        // Exhaustive sweep of the 4-bit instance
        for (int i = 0; i < 512; i++) begin
            op4(i % 16, (i / 16) % 16, i / 256);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder built around the team's single-bit `fulladder` cell. It accepts two operands plus carry-in through a start/busy/done handshake and feeds the `fulladder` one bit pair per clock, LSB first. A carry flip-flop closes the loop from `c_out` back to `c_in`. It is the sequencing stage wrapped around the combinational full adder, trading WIDTH cycles of latency for one adder cell.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range is 2 or more.
- `clk`, input, 1: the single clock; all state updates on the rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `start`, input, 1: request to begin an addition; sampled only when the block is idle.
- `a`, input, WIDTH: operand A; captured on the accepting edge.
- `b`, input, WIDTH: operand B; captured on the accepting edge.
- `c_in`, input, 1: carry-in; captured on the accepting edge.
- `busy`, output, 1: high while an addition is in progress.
- `done`, output, 1: one-cycle pulse; the result registers are valid from this cycle on.
- `sum`, output, WIDTH: last completed sum, held until the next completion.
- `c_out`, output, 1: carry out of the MSB for the last completed addition.
- `overflow`, output, 1: two's-complement overflow for the last completed addition.

## Operation
- The block has two states.
  - IDLE: `busy`=0.
  - RUN: `busy`=1.
- One `fulladder` instance:
  - inputs are opA_sh[0], opB_sh[0] and carry_q;
  - outputs are fa_sum and fa_cout.
- IDLE, when `start`=1 on an edge:
  - load opA_sh←`a`, opB_sh←`b`, carry_q←`c_in`;
  - set bit counter cnt←0;
  - go to RUN.
- IDLE, when `start`=0: hold.
- RUN, on each edge:
  - shift opA_sh and opB_sh right by 1;
  - shift fa_sum into the MSB of acc_sh, which also shifts right;
  - carry_q←fa_cout;
  - cnt←cnt+1.
- On the RUN edge where cnt=WIDTH-2, register prev_carry←fa_cout. This is the carry into the MSB.
- On the RUN edge where cnt=WIDTH-1 (the last bit), all of the following load together:
  - `sum`←{fa_sum, acc_sh[WIDTH-1:1]};
  - `c_out`←fa_cout;
  - `overflow`←fa_cout XOR prev_carry;
  - `done`←1;
  - state←IDLE.
- Result identity: `sum` = (`a`+`b`+`c_in`) mod 2^WIDTH, and `c_out` is bit WIDTH of the full sum.
- `start` in RUN is ignored. It is neither queued nor does it disturb the operation in progress.
- `sum`, `c_out` and `overflow` do not change during RUN. They update only on the completing edge.
- `a`, `b` and `c_in` may change freely after the accepting edge.
- Reset values: `busy`=0, `done`=0, `sum`=0, `c_out`=0, `overflow`=0, state=IDLE. The internal cnt, carry_q and shift registers also clear to 0.
- Reset in RUN aborts the operation immediately. No `done` is produced and the outputs return to their reset values.
- `rst` has priority over `start` on the same edge.

## Timing
- Let edge k be the edge where `start`=1 is sampled in IDLE. `busy` is high from after edge k through edge k+WIDTH.
- Bits are processed on edges k+1 … k+WIDTH, with bit i processed on edge k+1+i.
- `done`=1 and results are valid in the cycle after edge k+WIDTH. Latency from the start edge to `done` is WIDTH edges.
- `done` is high for exactly one cycle, and `busy`=0 in that cycle.
- Back-to-back: `start`=1 during the `done` cycle is accepted on the next edge. Sustained throughput is one result per WIDTH+1 cycles.
- `done` and `busy` are never high together.

## Test plan
- Basic, WIDTH=8: a=0x00, b=0x00, c_in=0 → after 8 edges, done pulses once with sum=0x00, c_out=0, overflow=0; busy high for exactly 8 cycles.
- Carry ripple through all bits: a=0xFF, b=0x01, c_in=0 → sum=0x00, c_out=1, overflow=0. Then a=0xFF, b=0xFF, c_in=1 → sum=0xFF, c_out=1, overflow=0.
- Signed overflow: a=0x7F, b=0x01, c_in=0 → sum=0x80, c_out=0, overflow=1. Then a=0x80, b=0x80 → sum=0x00, c_out=1, overflow=1.
- Handshake:
  - pulse start again 3 cycles into RUN with different operands → ignored, and the first result is delivered;
  - start held high in the done cycle → second op accepted; its done follows 9 cycles after the first done;
  - sum holds the first result until the second done.
- Reset mid-operation: assert rst at cnt=4 of a=0x55, b=0xAA → next cycle all outputs are 0, no done pulse, and busy=0. A following a=0x01, b=0x02 gives sum=0x03.
- Exhaustive, WIDTH=4: all 512 (a,b,c_in) combinations → sum, c_out and overflow match a reference model, with done exactly 4 edges after each accepting edge.
